demux_byte_sequencer: RTL and testbench



---
 rtl/demux_seq_pkg.sv | 21 ++
 rtl/demux_byte_sequencer_next_lane_finder.sv | 32 +++
 rtl/demux_byte_sequencer.sv | 129 ++++++++++++
 tb/tb_demux_byte_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/demux_seq_pkg.sv
// ----------------------------------------------------------------------------
// demux_seq_pkg
// Shared definitions for the demux byte sequencer:
//   LANES / SEL_W : lane count of the downstream 1:8 demux and its select width
//   state_t       : sequencer FSM states (IDLE, SHIFT, DONE)
//   lane_t        : lane index type
// ----------------------------------------------------------------------------
package demux_seq_pkg;

   localparam int LANES = 8;
   localparam int SEL_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [SEL_W-1:0] lane_t;

endpackage : demux_seq_pkg

// File: rtl/demux_byte_sequencer_next_lane_finder.sv
// ----------------------------------------------------------------------------
// next_lane_finder
// Purely combinational priority search over a lane mask.
//   mask  : in,  LANES  candidate lanes
//   cur   : in,  SEL_W  current lane (ignored when first=1)
//   first : in,  1      1 = search from lane 0, 0 = search strictly above cur
//   nxt   : out, SEL_W  lowest qualifying lane (0 when none found)
//   found : out, 1      a qualifying lane exists
// ----------------------------------------------------------------------------
module next_lane_finder
   import demux_seq_pkg::*;
(
   input  logic [LANES-1:0] mask,
   input  lane_t            cur,
   input  logic             first,
   output lane_t            nxt,
   output logic             found
);

   // Scan from the top lane down so the last hit is the lowest qualifying lane.
   always_comb begin
      nxt   = '0;
      found = 1'b0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (mask[i] && (first || (lane_t'(i) > cur))) begin
            nxt   = lane_t'(i);
            found = 1'b1;
         end
      end
   end

endmodule : next_lane_finder

// File: rtl/demux_byte_sequencer.sv
// ----------------------------------------------------------------------------
// demux_byte_sequencer
// Upstream feeder for the 1:8 demultiplexer. Accepts one byte per valid/ready
// handshake and, for every lane enabled in the byte's mask, drives the lane
// index on sel and the matching data bit on a, in ascending lane order.
//
// Ports:
//   clk        : in,  1      rising-edge clock
//   rst        : in,  1      asynchronous active-high reset
//   in_data    : in,  LANES  byte to distribute
//   in_valid   : in,  1      in_data / chan_mask valid
//   in_ready   : out, 1      block can accept a byte (IDLE)
//   chan_mask  : in,  LANES  bit i = 1 emits lane i; sampled at accept
//   a          : out, 1      serial bit to the demux data input
//   sel        : out, SEL_W  lane index to the demux select input
//   lane_valid : out, 1      a/sel carry a live lane this cycle
//   busy       : out, 1      a byte is in flight
//   done       : out, 1      one-cycle pulse when the byte has finished
//
// All outputs are decoded from registered state only, so there is no
// combinational path from the in_* inputs to any output.
// ----------------------------------------------------------------------------
module demux_byte_sequencer #(
   parameter int LANES = demux_seq_pkg::LANES,
   parameter int SEL_W = demux_seq_pkg::SEL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LANES-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LANES-1:0] chan_mask,
   output logic             a,
   output logic [SEL_W-1:0] sel,
   output logic             lane_valid,
   output logic             busy,
   output logic             done
);

   import demux_seq_pkg::*;

   state_t           state_q, state_d;
   logic [LANES-1:0] data_q,  data_d;
   logic [LANES-1:0] mask_q,  mask_d;
   lane_t            lane_q,  lane_d;

   // Single finder shared between accept (search the incoming mask from
   // lane 0) and SHIFT (search the latched mask above the current lane).
   logic [LANES-1:0] fin_mask;
   lane_t            fin_cur;
   logic             fin_first;
   lane_t            fin_nxt;
   logic             fin_found;

   next_lane_finder u_finder (
      .mask  (fin_mask),
      .cur   (fin_cur),
      .first (fin_first),
      .nxt   (fin_nxt),
      .found (fin_found)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         mask_q  <= '0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         lane_q  <= lane_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      mask_d    = mask_q;
      lane_d    = lane_q;
      fin_mask  = mask_q;
      fin_cur   = lane_q;
      fin_first = 1'b0;

      unique case (state_q)
         IDLE: begin
            // The mask is searched straight from the input so the first lane
            // is ready in lane_q on the cycle right after accept.
            fin_mask  = chan_mask;
            fin_first = 1'b1;
            if (in_valid) begin
               data_d = in_data;
               mask_d = chan_mask;
               if (fin_found) begin
                  lane_d  = fin_nxt;
                  state_d = SHIFT;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SHIFT: begin
            if (fin_found) begin
               lane_d = fin_nxt;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outside SHIFT, a and sel are forced to 0 so every demux output stays low.
   always_comb begin
      lane_valid = (state_q == SHIFT);
      in_ready   = (state_q == IDLE);
      busy       = (state_q != IDLE);
      done       = (state_q == DONE);
      sel        = lane_valid ? SEL_W'(lane_q) : '0;
      a          = lane_valid ? data_q[lane_q] : 1'b0;
   end

endmodule : demux_byte_sequencer

// File: tb/tb_demux_byte_sequencer.sv
module tb_demux_byte_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] chan_mask;
   logic       a;
   logic [2:0] sel;
   logic       lane_valid;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   demux_byte_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .chan_mask  (chan_mask),
      .a          (a),
      .sel        (sel),
      .lane_valid (lane_valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // One row = inputs applied before an edge, outputs expected just after it.
   typedef struct {
      logic       vin;
      logic [7:0] d;
      logic [7:0] m;
      logic       lv;
      logic [2:0] s;
      logic       av;
      logic       dn;
      logic       rdy;
      logic       bsy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic vin, input logic [7:0] d, input logic [7:0] m,
                      input logic lv, input logic [2:0] s, input logic av,
                      input logic dn, input logic rdy, input logic bsy);
      vec_t v;
      v.vin = vin; v.d = d; v.m = m;
      v.lv = lv; v.s = s; v.av = av; v.dn = dn; v.rdy = rdy; v.bsy = bsy;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic lv, input logic [2:0] s,
                      input logic av, input logic dn, input logic rdy, input logic bsy);
      n_checks++;
      if ({lane_valid, sel, a, done, in_ready, busy} !== {lv, s, av, dn, rdy, bsy}) begin
         n_fail++;
         $display("FAIL %s: got lv=%b sel=%0d a=%b done=%b rdy=%b busy=%b, expected lv=%b sel=%0d a=%b done=%b rdy=%b busy=%b",
                  nm, lane_valid, sel, a, done, in_ready, busy, lv, s, av, dn, rdy, bsy);
      end
   endtask

   // Shorthands for common expected rows.
   task automatic add_lane(input logic [2:0] s, input logic av);
      add(1'b0, 8'h00, 8'h00, 1'b1, s, av, 1'b0, 1'b0, 1'b1);
   endtask
   task automatic add_done();
      add(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask
   task automatic add_idle();
      add(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      chan_mask = 8'h00;

      // Full mask, data 0xA5 -> a = 1,0,1,0,0,1,0,1 on lanes 0..7
      add(1'b1, 8'hA5, 8'hFF, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      add_lane(3'd1, 1'b0); add_lane(3'd2, 1'b1); add_lane(3'd3, 1'b0);
      add_lane(3'd4, 1'b0); add_lane(3'd5, 1'b1); add_lane(3'd6, 1'b0);
      add_lane(3'd7, 1'b1);
      add_done(); add_idle();
      // Sparse mask 0x81, data 0x81 -> lanes 0 and 7 only
      add(1'b1, 8'h81, 8'h81, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      add_lane(3'd7, 1'b1);
      add_done(); add_idle();
      // Empty mask, data 0xFF -> straight to DONE, no lanes
      add(1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      add_idle();
      // Mask 0x5A (lanes 1,3,4,6), data 0x3C -> a = 0,1,1,0
      add(1'b1, 8'h3C, 8'h5A, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      add_lane(3'd3, 1'b1); add_lane(3'd4, 1'b1); add_lane(3'd6, 1'b0);
      add_done(); add_idle();

      // Reset state
      tick(); tick();
      chk("reset_state", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      tick();
      chk("post_reset_idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

      foreach (vecs[i]) begin
         in_valid  = vecs[i].vin;
         in_data   = vecs[i].d;
         chan_mask = vecs[i].m;
         tick();
         chk($sformatf("vec%0d", i), vecs[i].lv, vecs[i].s, vecs[i].av,
             vecs[i].dn, vecs[i].rdy, vecs[i].bsy);
      end

      // Backpressure: in_valid held high, mask changed mid-byte.
      in_valid  = 1'b1;
      in_data   = 8'h05;
      chan_mask = 8'h0F;
      tick(); chk("bp_k1", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(); chk("bp_k2", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      chan_mask = 8'h00;
      in_data   = 8'hFF;
      tick(); chk("bp_k3", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(); chk("bp_k4", 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(); chk("bp_k5_done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(); chk("bp_k6_idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(); chk("bp_2nd_done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      tick(); chk("bp_2nd_idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a 0xFF-mask byte.
      in_valid  = 1'b1;
      in_data   = 8'hFF;
      chan_mask = 8'hFF;
      tick(); in_valid = 1'b0;
      chk("rst_k1", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(); tick();
      chk("rst_k3", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1 chk("rst_async", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(); chk("rst_held", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      tick(); chk("rst_no_done", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      in_valid  = 1'b1;
      in_data   = 8'h02;
      chan_mask = 8'h02;
      tick(); in_valid = 1'b0;
      chk("rst_new_lane1", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(); chk("rst_new_done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(); chk("rst_new_idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_demux_byte_sequencer
